// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - shared widths, types and constants for the FP8 normalize/round stage
// Purpose: E4M3-style format parameters, packed result type, stage-1 pipeline record.
// Ports: none (package).
package fp8_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
  // {carry, hidden, mantissa[MAN_W], guard, round, sticky}
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(SUM_W + 1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp8_t;

  localparam fp8_t FP8_QNAN = fp8_t'({1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}});
  localparam fp8_t FP8_ZERO = fp8_t'('0);

  // Exponent carries one extra bit so a carry-out plus a rounding increment
  // can be seen as overflow rather than wrapping.
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [SUM_W-1:0] sum;
    logic             nan;
    logic             inf;
  } s1_t;

endpackage

// File: rtl/clz.sv
// rtl/clz.sv - combinational count-leading-zeros
// Purpose: number of zero bits above the most significant one; WIDTH_IN when input is zero.
// Ports: in_data (WIDTH_IN) -> out_lz (WIDTH_OUT).
module clz #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = $clog2(WIDTH_IN + 1)
) (
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic [WIDTH_OUT-1:0] out_lz
);

  logic w_found;

  always_comb begin
    out_lz  = WIDTH_OUT'(WIDTH_IN);
    w_found = 1'b0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      if (!w_found && in_data[i]) begin
        out_lz  = WIDTH_OUT'(WIDTH_IN - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp8_round.sv
// rtl/fp8_round.sv - combinational RNE rounding, overflow detection and packing
// Purpose: turns a normalized stage-1 record into the final packed FP8 value.
// Ports: in_s1 (s1_t) -> out_result (fp8_t), out_ovf (finite value rounded to Inf).
module fp8_round
  import fp8_pkg::*;
(
  input  s1_t  in_s1,
  output fp8_t out_result,
  output logic out_ovf
);

  logic             w_inc;
  logic [MAN_W+1:0] w_sig;
  logic [EXP_W:0]   w_exp;

  always_comb begin
    // Round to nearest even: guard set and (round | sticky | lsb).
    w_inc = in_s1.sum[2] & (in_s1.sum[1] | in_s1.sum[0] | in_s1.sum[3]);
    // {carry, hidden, mantissa}; carry is always clear coming out of stage 1,
    // so after the increment it flags a mantissa overflow.
    w_sig = in_s1.sum[SUM_W-1:3] + (MAN_W+2)'(w_inc);
    w_exp = in_s1.exp;
    if (w_sig[MAN_W+1]) begin
      w_exp = w_exp + (EXP_W+1)'(1);
    end else if (w_exp == '0 && w_sig[MAN_W]) begin
      // subnormal rounded up into the smallest normal
      w_exp = (EXP_W+1)'(1);
    end

    out_ovf        = 1'b0;
    out_result     = FP8_ZERO;
    out_result.sign = in_s1.sign;
    out_result.exp  = w_exp[EXP_W-1:0];
    out_result.man  = w_sig[MAN_W-1:0];

    if (in_s1.nan) begin
      out_result = FP8_QNAN;
    end else if (in_s1.inf) begin
      out_result.exp = '1;
      out_result.man = '0;
    end else if (w_exp >= {1'b0, {EXP_W{1'b1}}}) begin
      out_result.exp = '1;
      out_result.man = '0;
      out_ovf        = 1'b1;
    end
  end

endmodule

// File: rtl/fp8_normalize.sv
// rtl/fp8_normalize.sv - 2-stage post-add normalize/round pipeline for the FP8 adder
// Purpose: stage 1 normalizes (or denormalizes) the aligned sum via clz, stage 2 rounds RNE
//          and packs; valid/ready on both sides, full throughput when out_ready is high.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, in_sign, in_exp, in_sum,
//        in_nan, in_inf; out_valid/out_ready, out_result {sign,exp,man}, out_ovf.
module fp8_normalize
  import fp8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [SUM_W-1:0]     in_sum,
  input  logic                 in_nan,
  input  logic                 in_inf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_ovf
);

  localparam int CW = (LZ_W > EXP_W + 1) ? LZ_W : EXP_W + 1;

  logic [LZ_W-1:0] w_lz;
  logic [CW-1:0]   w_lz_m1;
  logic [CW-1:0]   w_exp_m1;
  logic [CW-1:0]   w_exp_c;
  logic [CW-1:0]   w_sh;
  s1_t             w_s1_d;
  s1_t             r_s1;
  logic            r_s1_valid;
  logic            w_s1_adv;
  fp8_t            w_res;
  logic            w_ovf;
  logic            r_out_valid;
  logic [EXP_W+MAN_W:0] r_out_result;
  logic            r_out_ovf;

  clz #(.WIDTH_IN(SUM_W)) u_clz (
    .in_data (in_sum),
    .out_lz  (w_lz)
  );

  always_comb begin
    w_s1_d      = '0;
    w_sh        = '0;
    w_lz_m1     = CW'(w_lz) - CW'(1);
    w_exp_m1    = CW'(in_exp) - CW'(1);
    w_exp_c     = CW'(in_exp);
    w_s1_d.sign = in_sign;
    w_s1_d.nan  = in_nan;
    w_s1_d.inf  = in_inf;
    if (in_sum == '0) begin
      // exact zero is always +0; an Inf special keeps its sign
      w_s1_d.sign = in_sign & in_inf;
    end else if (w_lz == '0) begin
      // carry out: shift right one, dropped bit folds into sticky
      w_s1_d.sum = {1'b0, in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
      w_s1_d.exp = (EXP_W+1)'(w_exp_c + CW'(1));
    end else begin
      // shift left until hidden is set, but never below exponent 1
      if (w_lz_m1 > w_exp_m1) begin
        w_sh       = w_exp_m1;
        w_s1_d.exp = '0;
      end else begin
        w_sh       = w_lz_m1;
        w_s1_d.exp = (EXP_W+1)'(w_exp_c - w_sh);
      end
      w_s1_d.sum = in_sum << w_sh;
      if (w_s1_d.exp == (EXP_W+1)'(1) && !w_s1_d.sum[SUM_W-2]) begin
        w_s1_d.exp = '0;
      end
    end
  end

  assign w_s1_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_d;
      end
    end
  end

  fp8_round u_round (
    .in_s1      (r_s1),
    .out_result (w_res),
    .out_ovf    (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_res;
        r_out_ovf    <= w_ovf;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovf    = r_out_ovf;

endmodule
